// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Single-outstanding instruction fetch front end. The unit requests one word
// at the current PC, waits for its data, then holds the instruction for the
// decoder until it is consumed or a redirect arrives. A redirect that lands
// while a read is in flight sends the unit to FLUSH, so the stale response is
// dropped before the next request goes out.
//
// Optional feature: define IFU_FETCH_CNT_EN to add o_fetch_cnt. It counts
// decoder handshakes that are not cancelled by a same-cycle redirect.
//
// Ports
//   i_clk           clock, rising edge
//   i_rst_n         synchronous active-low reset
//   o_imem_req      instruction memory read request
//   o_imem_addr     word-aligned fetch address (the internal PC)
//   i_imem_gnt      request accepted this cycle
//   i_imem_rvalid   read data valid
//   i_imem_rdata    read data (instruction word)
//   o_instr_valid   o_instr / o_pc hold a fetched instruction
//   o_instr         instruction word for the decoder
//   o_pc            address of o_instr
//   i_instr_ready   decoder consumes o_instr this cycle
//   i_pc_src        redirect request
//   i_pc_target     redirect address (low two bits are dropped)
//   o_fetch_cnt     handshake counter (only with IFU_FETCH_CNT_EN)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_instr_ready,
  input  logic        i_pc_src,
  input  logic [31:0] i_pc_target
`ifdef IFU_FETCH_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FLUSH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        vld_q, vld_d;
  logic        req_q, req_d;
  logic [31:0] redir_pc;

  // Masking keeps the full target bus in use while forcing word alignment.
  assign redir_pc = i_pc_target & ~32'h0000_0003;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (i_pc_src) begin
          pc_d = redir_pc;
          // A grant in the same cycle means a read is already in flight.
          state_d = i_imem_gnt ? S_FLUSH : S_REQ;
        end else if (i_imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_pc_src) begin
          pc_d  = redir_pc;
          vld_d = 1'b0;
          // Data arriving with the redirect is simply dropped here.
          state_d = i_imem_rvalid ? S_REQ : S_FLUSH;
        end else if (i_imem_rvalid) begin
          instr_d = i_imem_rdata;
          ipc_d   = pc_q;
          vld_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Redirect wins over a decoder handshake in the same cycle.
        if (i_pc_src) begin
          pc_d    = redir_pc;
          vld_d   = 1'b0;
          state_d = S_REQ;
        end else if (i_instr_ready) begin
          pc_d    = pc_q + 32'd4;
          vld_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_FLUSH: begin
        if (i_pc_src) pc_d = redir_pc;
        if (i_imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      ipc_q   <= RESET_PC;
      vld_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      req_q   <= req_d;
    end
  end

  assign o_imem_req    = req_q;
  assign o_imem_addr   = pc_q;
  assign o_instr_valid = vld_q;
  assign o_instr       = instr_q;
  assign o_pc          = ipc_q;

`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (vld_q && i_instr_ready && !i_pc_src) fetch_cnt_d = fetch_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) fetch_cnt_q <= 32'h0;
    else          fetch_cnt_q <= fetch_cnt_d;
  end

  assign o_fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit. A transaction-level model (request pending,
// response-to-drop, instruction held) tracks the expected outputs and is
// compared against the DUT on every falling edge. Directed sequences with
// literal expectations run first, then randomized traffic including resets,
// redirects and spurious read-valid pulses.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_ready = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] pc_target = 32'h0;
`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_gnt   (imem_gnt),
    .i_imem_rvalid(imem_rvalid),
    .i_imem_rdata (imem_rdata),
    .o_instr_valid(instr_valid),
    .o_instr      (instr),
    .o_pc         (pc),
    .i_instr_ready(instr_ready),
    .i_pc_src     (pc_src),
    .i_pc_target  (pc_target)
`ifdef IFU_FETCH_CNT_EN
    ,
    .o_fetch_cnt  (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit          m_en      = 1'b0;  // checking starts after the first reset edge
  bit          m_started = 1'b0;  // one quiet cycle after reset
  bit          m_pending = 1'b0;  // a granted read has not returned yet
  bit          m_discard = 1'b0;  // that read's data must be dropped
  bit          m_valid   = 1'b0;
  logic [31:0] m_pc      = RST_PC;
  logic [31:0] m_instr   = 32'h0;
  logic [31:0] m_ipc     = RST_PC;
  logic [31:0] m_cnt     = 32'h0;

  function automatic bit m_requesting();
    return m_started && !m_pending && !m_valid;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_en = 1'b1;
      m_started = 1'b0; m_pending = 1'b0; m_discard = 1'b0; m_valid = 1'b0;
      m_pc = RST_PC; m_instr = 32'h0; m_ipc = RST_PC; m_cnt = 32'h0;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_requesting()) begin
      if (imem_gnt) begin
        m_pending = 1'b1;
        m_discard = pc_src;
      end
      if (pc_src) m_pc = {pc_target[31:2], 2'b00};
    end else if (m_pending) begin
      if (imem_rvalid) begin
        if (!m_discard && !pc_src) begin
          m_valid = 1'b1;
          m_instr = imem_rdata;
          m_ipc   = m_pc;
        end
        m_pending = 1'b0;
      end else if (pc_src) begin
        m_discard = 1'b1;
      end
      if (pc_src) m_pc = {pc_target[31:2], 2'b00};
    end else if (m_valid) begin
      if (pc_src) begin
        m_pc = {pc_target[31:2], 2'b00};
        m_valid = 1'b0;
      end else if (instr_ready) begin
        m_pc = m_pc + 32'd4;
        m_valid = 1'b0;
        m_cnt = m_cnt + 32'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_en) begin
      chk("req",   {31'h0, imem_req},    {31'h0, m_requesting()});
      chk("addr",  imem_addr,            m_pc);
      chk("valid", {31'h0, instr_valid}, {31'h0, m_valid});
      chk("instr", instr,                m_instr);
      chk("pc",    pc,                   m_ipc);
`ifdef IFU_FETCH_CNT_EN
      chk("cnt",   fetch_cnt,            m_cnt);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc(input bit gnt, input bit rv, input logic [31:0] rd,
                     input bit rdy, input bit src, input logic [31:0] tgt);
    imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
    instr_ready = rdy; pc_src = src; pc_target = tgt;
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // From REQ: grant, return data, accept.
  task automatic fetch_one(input logic [31:0] rd);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, rd,    1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    @(negedge clk);
    // Reset state
    rst_n = 1'b0;
    idle_cyc(); idle_cyc();
    chk("rst_req",   {31'h0, imem_req},    32'h0);
    chk("rst_addr",  imem_addr,            RST_PC);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr,                32'h0);
    chk("rst_pc",    pc,                   RST_PC);
    rst_n = 1'b1;

    // First fetch at minimum latency
    idle_cyc();
    chk("d1_req",  {31'h0, imem_req}, 32'h1);
    chk("d1_addr", imem_addr,         32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("d1_req_wait", {31'h0, imem_req}, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0033, 1'b0, 1'b0, 32'h0);
    chk("d1_valid", {31'h0, instr_valid}, 32'h1);
    chk("d1_instr", instr, 32'h0000_0033);
    chk("d1_pc",    pc,    32'h0);

    // Decoder stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      idle_cyc();
      chk("d2_instr", instr, 32'h0000_0033);
      chk("d2_pc",    pc,    32'h0);
      chk("d2_req",   {31'h0, imem_req}, 32'h0);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("d2_next_addr", imem_addr, 32'h4);
    chk("d2_next_req",  {31'h0, imem_req}, 32'h1);

    // Redirect while waiting for data
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    chk("d3_req_flush", {31'h0, imem_req}, 32'h0);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    chk("d3_valid", {31'h0, instr_valid}, 32'h0);
    chk("d3_addr",  imem_addr, 32'h0000_0100);
    chk("d3_req",   {31'h0, imem_req}, 32'h1);

    // PC wrap at the top of the address space
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("d4_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    chk("d4_pc", pc, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("d4_wrap", imem_addr, 32'h0);

    // Reset pulse during WAIT, then a late response
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    idle_cyc();
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    chk("d5_valid", {31'h0, instr_valid}, 32'h0);
    chk("d5_addr",  imem_addr, RST_PC);
    cyc(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    chk("d5_stray_valid", {31'h0, instr_valid}, 32'h0);
    chk("d5_stray_req",   {31'h0, imem_req}, 32'h1);

    // Three accepted plus one redirected in HOLD with ready high
    fetch_one(32'h0000_0001);
    fetch_one(32'h0000_0002);
    fetch_one(32'h0000_0003);
    chk("d6_addr3", imem_addr, RST_PC + 32'd12);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200);
    chk("d6_redir_addr", imem_addr, 32'h0000_0200);
`ifdef IFU_FETCH_CNT_EN
    chk("d6_cnt", fetch_cnt, 32'd3);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      imem_gnt    = $urandom_range(0, 1) == 1;
      imem_rvalid = m_pending ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      imem_rdata  = $urandom;
      instr_ready = $urandom_range(0, 1) == 1;
      pc_src      = ($urandom_range(0, 9) == 0);
      pc_target   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
